// File: rtl/booth_multiplier_if.sv
// Handshake and data bundle for the Booth multiplier.
// Defining BOOTH_MULT_HI_EN adds the upper product word out_hi.
interface booth_multiplier_if #(
    parameter int WIDTH = 32
) ();
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] out;
    logic             overflow;
    logic             busy;
    logic             ready;
`ifdef BOOTH_MULT_HI_EN
    logic [WIDTH-1:0] out_hi;
`endif

`ifdef BOOTH_MULT_HI_EN
    modport master (
        output ena, start, multiplicand, multiplier,
        input  out, overflow, busy, ready, out_hi
    );
    modport slave (
        input  ena, start, multiplicand, multiplier,
        output out, overflow, busy, ready, out_hi
    );
`else
    modport master (
        output ena, start, multiplicand, multiplier,
        input  out, overflow, busy, ready
    );
    modport slave (
        input  ena, start, multiplicand, multiplier,
        output out, overflow, busy, ready
    );
`endif
endinterface

// File: rtl/booth_multiplier.sv
// Multicycle signed radix-2 Booth multiplier, one add/sub plus shift per cycle.
// Optional macro BOOTH_MULT_HI_EN exposes the upper product word as out_hi.
module booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clrn,
    booth_multiplier_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH:0]   a_reg;       // one guard bit so M = -2^(WIDTH-1) negates exactly
    logic [WIDTH-1:0] q_reg;
    logic             q1_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] out_reg;
    logic             overflow_reg;
`ifdef BOOTH_MULT_HI_EN
    logic [WIDTH-1:0] out_hi_reg;
`endif

    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     a_shift;
    logic [WIDTH-1:0]   q_shift;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     top_bits;
    logic               overflow_next;
    logic               last_iter;
    logic               capture;

    assign m_ext     = {m_reg[WIDTH-1], m_reg};
    assign last_iter = (count_reg == CW'(WIDTH - 1));
    assign capture   = bus.start && (state_reg != RUN);

    always_comb begin
        sum = a_reg;
        unique case ({q_reg[0], q1_reg})
            2'b01:   sum = a_reg + m_ext;
            2'b10:   sum = a_reg - m_ext;
            default: sum = a_reg;
        endcase
    end

    assign a_shift  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_shift  = {sum[0], q_reg[WIDTH-1:1]};
    // After the final shift the exact product sits in the low 2*WIDTH bits of {A,Q}.
    assign product  = {a_shift[WIDTH-1:0], q_shift};
    assign top_bits = product[2*WIDTH-1:WIDTH-1];
    assign overflow_next = !((&top_bits) || !(|top_bits));

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg <= IDLE;
        end else if (bus.ena) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            count_reg    <= '0;
            a_reg        <= '0;
            q_reg        <= '0;
            q1_reg       <= 1'b0;
            m_reg        <= '0;
            out_reg      <= '0;
            overflow_reg <= 1'b0;
`ifdef BOOTH_MULT_HI_EN
            out_hi_reg   <= '0;
`endif
        end else if (bus.ena) begin
            if (capture) begin
                m_reg     <= bus.multiplicand;
                a_reg     <= '0;
                q_reg     <= bus.multiplier;
                q1_reg    <= 1'b0;
                count_reg <= '0;
            end else if (state_reg == RUN) begin
                a_reg     <= a_shift;
                q_reg     <= q_shift;
                q1_reg    <= q_reg[0];
                count_reg <= last_iter ? '0 : count_reg + CW'(1);
                if (last_iter) begin
                    out_reg      <= product[WIDTH-1:0];
                    overflow_reg <= overflow_next;
`ifdef BOOTH_MULT_HI_EN
                    out_hi_reg   <= product[2*WIDTH-1:WIDTH];
`endif
                end
            end
        end
    end

    assign bus.out      = out_reg;
    assign bus.overflow = overflow_reg;
    assign bus.busy     = (state_reg == RUN);
    assign bus.ready    = (state_reg == DONE);
`ifdef BOOTH_MULT_HI_EN
    assign bus.out_hi   = out_hi_reg;
`endif
endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: directed vectors queue expected results,
// a negedge monitor pops and compares on each rising ready.
module tb_booth_multiplier;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] o;
        logic         v;
        logic [W-1:0] h;
    } exp_t;

    logic clk;
    logic clrn;
    booth_multiplier_if #(.WIDTH(W)) bus ();

    booth_multiplier #(.WIDTH(W)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rises = 0;
    int   busy_cnt = 0;
    logic ready_prev = 1'b0;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.ready && !ready_prev) begin
            rises++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got out=0x%0h with no result queued", bus.out);
            end else begin
                e = exp_q.pop_front();
                $display("[TB] cyc %0d ready out=0x%08h ovf=%0b (want 0x%08h ovf=%0b)",
                         cyc, bus.out, bus.overflow, e.o, e.v);
                chk("out", 64'(bus.out), 64'(e.o));
                chk("overflow", 64'(bus.overflow), 64'(e.v));
`ifdef BOOTH_MULT_HI_EN
                chk("out_hi", 64'(bus.out_hi), 64'(e.h));
`endif
            end
        end
        ready_prev = bus.ready;
        if (bus.busy) busy_cnt++;
    end

    task automatic push(input logic [W-1:0] o, input logic v, input logic [W-1:0] h);
        exp_t e;
        e.o = o; e.v = v; e.h = h;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] q, output int cap);
        @(negedge clk);
        busy_cnt = 0;
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        @(posedge clk);
        #1 cap = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus.multiplicand = 32'hDEADBEEF;
        bus.multiplier = 32'h13579BDF;
    endtask

    task automatic wait_ready(output int rc);
        rc = -1;
        for (int i = 0; i < 200 && rc < 0; i++) begin
            @(negedge clk);
            if (bus.ready) rc = cyc;
        end
        if (rc < 0) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got no ready within 200 cycles, expected a ready pulse");
        end
    endtask

    task automatic run_one(input logic [W-1:0] m, input logic [W-1:0] q,
                           input logic [W-1:0] o, input logic v, input logic [W-1:0] h);
        int c, r;
        push(o, v, h);
        issue(m, q, c);
        wait_ready(r);
        chk("latency", 64'(r - c), 64'(W));
    endtask

    initial begin
        int c, r, r1, r2, n, rises_before;
        clrn = 1'b0;
        bus.ena = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        repeat (3) @(negedge clk);
        chk("reset_out", 64'(bus.out), 64'h0);
        chk("reset_overflow", 64'(bus.overflow), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        chk("reset_ready", 64'(bus.ready), 64'h0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // 3 x 4 with busy width and single-cycle ready
        push(32'h0000000C, 1'b0, 32'h0);
        issue(32'd3, 32'd4, c);
        wait_ready(r);
        chk("latency_3x4", 64'(r - c), 64'(W));
        chk("busy_cycles", 64'(busy_cnt), 64'(W));
        @(negedge clk);
        chk("ready_pulse_low", 64'(bus.ready), 64'h0);

        run_one(32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 1'b0, 32'hFFFFFFFF);
        run_one(32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 32'hFFFFFFFF);
        run_one(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'h00000000);
        run_one(32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 32'h00000001);
        run_one(32'h00000000, 32'h12345678, 32'h00000000, 1'b0, 32'h00000000);
        run_one(32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 32'h40000000);

        // back-to-back with start held high, operands disturbed during RUN
        push(32'd25, 1'b0, 32'h0);
        push(32'hFFFFFFFA, 1'b0, 32'hFFFFFFFF);
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 32'd5;
        bus.multiplier = 32'd5;
        @(posedge clk);
        #1 c = cyc;
        @(negedge clk);
        bus.multiplicand = 32'hFFFFFFFE;
        bus.multiplier = 32'd3;
        wait_ready(r1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.multiplicand = 32'd9;
        bus.multiplier = 32'd9;
        wait_ready(r2);
        chk("b2b_first_latency", 64'(r1 - c), 64'(W));
        chk("b2b_spacing", 64'(r2 - r1), 64'(W + 1));

        // asynchronous reset mid-run
        issue(32'd100, 32'd100, c);
        repeat (9) @(negedge clk);
        rises_before = rises;
        clrn = 1'b0;
        #1;
        chk("midrun_reset_out", 64'(bus.out), 64'h0);
        chk("midrun_reset_busy", 64'(bus.busy), 64'h0);
        chk("midrun_reset_ready", 64'(bus.ready), 64'h0);
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        repeat (40) @(negedge clk);
        chk("no_ready_after_reset", 64'(rises), 64'(rises_before));
        run_one(32'd2, 32'd2, 32'd4, 1'b0, 32'h0);

        // ena low for 5 cycles mid-run
        push(32'hFFFFFFEB, 1'b0, 32'hFFFFFFFF);
        issue(32'd7, 32'hFFFFFFFD, c);
        repeat (9) @(negedge clk);
        bus.ena = 1'b0;
        repeat (5) @(negedge clk);
        bus.ena = 1'b1;
        wait_ready(r);
        chk("ena_stall_latency", 64'(r - c), 64'(W + 5));

        // ena low while ready is high holds ready
        push(32'd42, 1'b0, 32'h0);
        issue(32'd6, 32'd7, c);
        wait_ready(r);
        bus.ena = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ready) n++;
        end
        chk("ready_held_by_ena", 64'(n), 64'd3);
        bus.ena = 1'b1;
        @(negedge clk);
        chk("ready_drops_after_ena", 64'(bus.ready), 64'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
